// File: rtl/spi_slave_regfile.sv
// SPI mode-0 responder for 16-bit command + 16-bit data frames backed by a local register file.
// The SPI pins are oversampled in the clk domain, so every piece of logic here runs on clk.
module spi_slave_regfile #(
   parameter logic [2:0] SLAVE_ID = 3'd0,
   parameter int         NUM_REGS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sclk_in,
   input  logic        cs_n_in,
   input  logic        mosi_in,
   output logic        miso_out,
   output logic        miso_oe,
   input  logic [7:0]  host_addr,
   output logic [15:0] host_rdata,
   output logic        wr_pulse,
   output logic [7:0]  wr_addr,
   output logic [15:0] wr_data,
   output logic        rd_pulse,
   output logic        frame_err
);

   localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
   state_t state, state_nx;

   logic [1:0]    sclk_sync, cs_sync, mosi_sync;
   logic          sclk_d, cs_d;
   logic          sclk_rise, sclk_fall, cs_act, cs_fall;

   logic [15:0]   shift, shift_in, tx;
   logic [5:0]    bitcnt;
   logic [7:0]    cmd_addr;
   logic          cmd_rd, match, cmd_match;
   logic          start, abort, in_frame, cmd_last, data_last, commit;
   logic [AW-1:0] cmd_idx, wr_idx, host_idx;
   logic          host_hit;
   logic [15:0]   regs [NUM_REGS];

   // The CS synchronizer resets to "selected" so that a reset in the middle
   // of a frame cannot fake a falling edge; a real high-then-low is required.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync <= '0;
         cs_sync   <= '0;
         mosi_sync <= '0;
         sclk_d    <= 1'b0;
         cs_d      <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[0], sclk_in};
         cs_sync   <= {cs_sync[0], cs_n_in};
         mosi_sync <= {mosi_sync[0], mosi_in};
         sclk_d    <= sclk_sync[1];
         cs_d      <= cs_sync[1];
      end
   end

   assign sclk_rise = sclk_sync[1] & ~sclk_d;
   assign sclk_fall = ~sclk_sync[1] & sclk_d;
   assign cs_act    = ~cs_sync[1];
   assign cs_fall   = cs_d & ~cs_sync[1];

   assign shift_in  = {shift[14:0], mosi_sync[1]};
   assign cmd_idx   = shift_in[3 +: AW];
   assign wr_idx    = cmd_addr[AW-1:0];
   assign host_idx  = host_addr[AW-1:0];
   assign cmd_match = (shift_in[13:11] == SLAVE_ID) &&
                      ({1'b0, shift_in[10:3]} < 9'(NUM_REGS));
   assign host_hit  = {1'b0, host_addr} < 9'(NUM_REGS);

   assign in_frame  = (state == CMD || state == DATA) && cs_act;
   assign cmd_last  = (state == CMD)  && cs_act && sclk_rise && (bitcnt == 6'd15);
   assign data_last = (state == DATA) && cs_act && sclk_rise && (bitcnt == 6'd31);
   assign commit    = data_last && !cmd_rd && match;
   assign miso_oe   = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      start    = 1'b0;
      abort    = 1'b0;
      unique case (state)
         IDLE: if (cs_fall) begin
            state_nx = CMD;
            start    = 1'b1;
         end
         CMD: begin
            if (!cs_act) begin
               state_nx = IDLE;
               abort    = 1'b1;
            end else if (cmd_last) begin
               state_nx = DATA;
            end
         end
         DATA: begin
            if (!cs_act) begin
               state_nx = IDLE;
               abort    = 1'b1;
            end else if (data_last) begin
               state_nx = DONE;
            end
         end
         DONE: if (!cs_act) state_nx = IDLE;
      endcase
   end

   // MISO already carries bit 15 after the 16th rise, so each fall re-drives
   // the current head of tx and then advances; bit 15 is still there at rise 17.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift     <= '0;
         tx        <= '0;
         bitcnt    <= '0;
         cmd_addr  <= '0;
         cmd_rd    <= 1'b0;
         match     <= 1'b0;
         miso_out  <= 1'b0;
         rd_pulse  <= 1'b0;
         wr_pulse  <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         frame_err <= 1'b0;
      end else begin
         rd_pulse  <= 1'b0;
         wr_pulse  <= 1'b0;
         frame_err <= abort;
         if (start) begin
            shift    <= '0;
            tx       <= '0;
            bitcnt   <= '0;
            cmd_rd   <= 1'b0;
            match    <= 1'b0;
            miso_out <= 1'b0;
         end else if (in_frame && sclk_rise) begin
            shift  <= shift_in;
            bitcnt <= bitcnt + 6'd1;
         end
         if (cmd_last) begin
            cmd_addr <= shift_in[10:3];
            cmd_rd   <= shift_in[1];
            match    <= cmd_match;
            if (shift_in[1] && cmd_match) begin
               tx       <= regs[cmd_idx];
               miso_out <= regs[cmd_idx][15];
               rd_pulse <= 1'b1;
            end else begin
               tx       <= '0;
               miso_out <= 1'b0;
            end
         end else if (state == DATA && cs_act && sclk_fall) begin
            miso_out <= tx[15];
            tx       <= {tx[14:0], 1'b0};
         end
         if (commit) begin
            wr_pulse <= 1'b1;
            wr_addr  <= cmd_addr;
            wr_data  <= shift_in;
         end
         if (state != IDLE && state_nx == IDLE) miso_out <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         host_rdata <= '0;
      end else begin
         if (commit) regs[wr_idx] <= shift_in;
         host_rdata <= host_hit ? regs[host_idx] : '0;
      end
   end

endmodule

// File: doc/spi_slave_regfile.md
Name: spi_slave_regfile

Overview:
- SPI Mode 0 (CPOL=0, CPHA=0) responder for the team's 16-bit command + 16-bit data SPI master.
- Oversamples SCLK, CS_N and MOSI in the clk domain and decodes the command word.
- Performs writes into, and reads from, a local register file; returns read data on MISO during the data phase.
- One instance sits behind each master chip-select line.

Parameters:
- SLAVE_ID, 0: 3-bit ID this instance answers to; compared with cmd[13:11].
- NUM_REGS, 16: register count (1..256); valid addresses 0..NUM_REGS-1.

Ports:
- clk  input  1  system clock; must be ≥ 8x SCLK frequency (SCLK high/low ≥ 4 clk each).
- rst  input  1  asynchronous, active-high reset.
- sclk_in  input  1  SPI clock from master.
- cs_n_in  input  1  active-low chip select for this slave.
- mosi_in  input  1  master-out data.
- miso_out  output  1  slave-out data.
- miso_oe  output  1  MISO output enable; 1 while selected.
- host_addr  input  8  local read-back address.
- host_rdata  output  16  register[host_addr], registered; 0 if out of range.
- wr_pulse  output  1  1-cycle pulse when an SPI write commits.
- wr_addr  output  8  address of the last committed write.
- wr_data  output  16  data of the last committed write.
- rd_pulse  output  1  1-cycle pulse when read data is loaded for MISO.
- frame_err  output  1  1-cycle pulse when CS_N rises before 32 rising SCLK edges.

Behaviour:
- Input conditioning
  - sclk_in, cs_n_in and mosi_in each pass through a 2-flop synchronizer.
  - Rise/fall detection compares synced SCLK with a 3rd delay flop.
  - cs active = synced cs_n == 0.
- Command word fields
  - [15:14] reserved; [13:11] id; [10:3] addr; [2] reserved; [1] rd; [0] reserved.
  - Bits arrive MSB first, sampled on SCLK rising edges.
- Reset values
  - miso_out=0, miso_oe=0, host_rdata=0, wr_pulse=0, wr_addr=0, wr_data=0, rd_pulse=0, frame_err=0.
  - All registers = 0; state = IDLE; bit counter = 0.
- State machine
  - IDLE: miso_oe=0, miso_out=0. Synced CS falling → clear the shifters, bitcnt=0, go to CMD.
  - CMD: on each SCLK rise, shift in MOSI and increment bitcnt.
    - On the 16th rise, latch cmd and set match = (id==SLAVE_ID) && (addr<NUM_REGS).
    - If rd && match: load tx shifter with reg[addr], drive miso_out = reg[addr][15] the next clk, pulse rd_pulse.
    - If rd && !match: load 0.
    - Then go to DATA.
  - DATA, read: on each SCLK fall, shift the tx shifter left and drive the next bit. The master samples 16 bits on rises 17..32.
  - DATA, write: on each SCLK rise, shift in MOSI.
    - On the 32nd rise, if !rd && match: reg[addr] <= {shift[14:0], mosi}, update wr_addr/wr_data, pulse wr_pulse the next clk.
    - Go to DONE after the 32nd rise in both read and write.
  - DONE: hold miso_out; extra SCLK edges are ignored. Synced CS high → IDLE.
- Chip select and MISO
  - miso_oe = 1 in CMD/DATA/DONE. miso_out = 0 throughout CMD.
- Aborted frames
  - CS rising while in CMD or DATA (before the 32nd rise) → IDLE, frame_err pulse.
  - No register write and no wr_pulse occur.
  - A new CS falling edge always starts a fresh frame.
- Mismatched ID or out-of-range address
  - No write, read data 0, no rd_pulse/wr_pulse; the frame is otherwise tracked normally (no frame_err).
- host_rdata updates 1 clk after host_addr.
  - If host_addr equals the address committed in the same cycle, it shows the new value one cycle after the commit.
- rst mid-frame: immediate return to reset values; the remainder of the frame is ignored until CS has been seen high and then low again.
- Latency budget: the 16th rise is seen ≤3 clk after the pad edge; MISO updates ≤4 clk after the pad edge, before the next SCLK fall.

Test Plan:
- Write: SLAVE_ID=2, master-equivalent stimulus at clk/16 SCLK, cmd 0x1028 (id 2, addr 0x05, write), data 0xA5C3.
  - Expect wr_pulse once, wr_addr=0x05, wr_data=0xA5C3, host_addr=0x05 → host_rdata=0xA5C3, frame_err=0.
- Read-back: cmd 0x102A (addr 0x05, rd) → MISO bits sampled on data rises = 0xA5C3, rd_pulse once, miso_oe high only while CS low.
- Out-of-range address: cmd 0x1100 (addr 0x20) write 0xFFFF → no wr_pulse; read cmd 0x1102 → 0x0000; all registers unchanged.
- ID mismatch: cmd 0x1828 (id 3) write 0x1234 → no wr_pulse, reg[5] still 0xA5C3; read 0x182A → MISO all 0.
- Abort: write cmd 0x1028 with data 0x0F0F, CS deasserted after 20 rising edges → frame_err one pulse, reg[5]=0xA5C3; next full frame succeeds.
- Reset mid-frame: assert rst during bit 25 of a write → all outputs/registers 0; stray SCLK edges before CS rises cause no write; the following frame works normally.
